// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwdSelT;

  localparam logic [3:0] REG_PC = 4'hF;

  typedef struct packed {
    logic [3:0] wa3;
    logic       regWrite;
    logic       memtoReg;
    logic       pcSrc;
  } stageT;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    stageT      ctl;
  } stageET;

  // R15 reads return PC+8 from fetch, so they never depend on an in-flight write
  function automatic logic srcMatch(input logic [3:0] src, input logic [3:0] dst);
    return (src != REG_PC) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W status shift register with bubble insertion and condition gating
module hazard_scoreboard
  import hazard_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flushE,
  input  logic   condExE,
  input  stageET stageD,
  output stageET stageE,
  output stageT  stageM,
  output stageT  stageW
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stageE <= '0;
      stageM <= '0;
      stageW <= '0;
    end else begin
      stageE <= flushE ? '0 : stageD;
      // a failed condition cancels the write side effects as the instruction leaves Execute
      stageM <= '{wa3:      stageE.ctl.wa3,
                  regWrite: stageE.ctl.regWrite & condExE,
                  memtoReg: stageE.ctl.memtoReg,
                  pcSrc:    stageE.ctl.pcSrc & condExE};
      stageW <= stageM;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall, flush and forwarding control for the five-stage pipeline
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount
);

  stageET stageD;
  stageET stageE;
  stageT  stageM;
  stageT  stageW;
  logic   ldStall;
  logic   pcWrPend;
  logic   unusedBits;

  assign stageD = '{ra1: RA1D, ra2: RA2D,
                    ctl: '{wa3: WA3D, regWrite: RegWriteD, memtoReg: MemtoRegD, pcSrc: PCSrcD}};

  hazard_scoreboard uScoreboard (
    .clk     (clk),
    .reset   (reset),
    .flushE  (FlushE),
    .condExE (CondExE),
    .stageD  (stageD),
    .stageE  (stageE),
    .stageM  (stageM),
    .stageW  (stageW)
  );

  function automatic fwdSelT fwdSel(input logic [3:0] src, input stageT m, input stageT w);
    if (m.regWrite && srcMatch(src, m.wa3))
      return FWD_MEM;
    else if (w.regWrite && srcMatch(src, w.wa3))
      return FWD_WB;
    else
      return FWD_NONE;
  endfunction

  assign ForwardAE = fwdSel(stageE.ra1, stageM, stageW);
  assign ForwardBE = fwdSel(stageE.ra2, stageM, stageW);

  // a taken branch squashes the dependent instruction, so the load-use stall is moot
  assign ldStall  = (srcMatch(RA1D, stageE.ctl.wa3) || srcMatch(RA2D, stageE.ctl.wa3))
                  && stageE.ctl.memtoReg && stageE.ctl.regWrite && !BranchTakenE;
  assign pcWrPend = PCSrcD | stageE.ctl.pcSrc | stageM.pcSrc;

  assign StallD = ldStall;
  assign StallF = ldStall | pcWrPend;
  assign FlushE = ldStall | BranchTakenE;
  assign FlushD = pcWrPend | stageW.pcSrc | BranchTakenE;

  assign unusedBits = stageM.memtoReg ^ stageW.memtoReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      StallCount <= '0;
    else if (StallF && (StallCount != '1))
      StallCount <= StallCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vector table plus randomized reference-model check of hazard_unit
module tb_hazard_unit;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          RA1D, RA2D, WA3D;
  logic                RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE;
  logic [1:0]          ForwardAE, ForwardBE;
  logic                StallF, StallD, FlushD, FlushE;
  logic [TB_CNT_W-1:0] StallCount;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount)
  );

  typedef struct {
    bit         rst;
    logic [3:0] ra1, ra2, wa3;
    bit         rw, mem, pcs, cond, br;
    logic [1:0] fa, fb;
    bit         sf, sd, fd, fe;
    int         cnt;
  } vecT;

  function automatic vecT mk(bit rst, logic [3:0] ra1, logic [3:0] ra2, logic [3:0] wa3,
                             bit rw, bit mem, bit pcs, bit cond, bit br,
                             logic [1:0] fa, logic [1:0] fb, bit sf, bit sd, bit fd, bit fe, int cnt);
    vecT v;
    v.rst = rst; v.ra1 = ra1; v.ra2 = ra2; v.wa3 = wa3;
    v.rw = rw; v.mem = mem; v.pcs = pcs; v.cond = cond; v.br = br;
    v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe; v.cnt = cnt;
    return v;
  endfunction

  // Reference model: in-flight instructions, index 0 = Execute, 1 = Memory, 2 = Writeback
  typedef struct {
    logic [3:0] ra1, ra2, wa3;
    bit         rw, mem, pcs;
  } instT;

  instT pipe[3];
  int   mCount;
  logic [1:0] eFa, eFb;
  bit   eSf, eSd, eFd, eFe;

  task automatic modelClear();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    mCount = 0;
  endtask

  function automatic logic [1:0] modelFwd(logic [3:0] src);
    if (src == 4'hF) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].rw && pipe[k].wa3 == src) return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic modelEval();
    bit dep, ld, pend;
    dep  = (RA1D != 4'hF && RA1D == pipe[0].wa3) || (RA2D != 4'hF && RA2D == pipe[0].wa3);
    ld   = dep && pipe[0].mem && pipe[0].rw && !BranchTakenE;
    pend = PCSrcD || pipe[0].pcs || pipe[1].pcs;
    eFa = modelFwd(pipe[0].ra1);
    eFb = modelFwd(pipe[0].ra2);
    eSd = ld;
    eSf = ld || pend;
    eFe = ld || BranchTakenE;
    eFd = pend || pipe[2].pcs || BranchTakenE;
  endtask

  task automatic modelStep();
    instT leaving;
    pipe[2] = pipe[1];
    leaving = pipe[0];
    if (!CondExE) begin leaving.rw = 0; leaving.pcs = 0; end
    pipe[1] = leaving;
    if (eFe) pipe[0] = '{default: 0};
    else     pipe[0] = '{ra1: RA1D, ra2: RA2D, wa3: WA3D, rw: RegWriteD, mem: MemtoRegD, pcs: PCSrcD};
    if (eSf && mCount < CNT_MAX) mCount++;
  endtask

  task automatic compare(string name, logic [1:0] fa, logic [1:0] fb,
                         bit sf, bit sd, bit fd, bit fe, int cnt);
    checkCount++;
    if (ForwardAE === fa && ForwardBE === fb && StallF === sf && StallD === sd &&
        FlushD === fd && FlushE === fe && int'(StallCount) == cnt)
      passCount++;
    else
      $display("FAIL %s: got fa=%0d fb=%0d sf=%0d sd=%0d fd=%0d fe=%0d cnt=%0d, expected fa=%0d fb=%0d sf=%0d sd=%0d fd=%0d fe=%0d cnt=%0d",
               name, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount,
               fa, fb, sf, sd, fd, fe, cnt);
  endtask

  task automatic drive(logic [3:0] ra1, logic [3:0] ra2, logic [3:0] wa3,
                       bit rw, bit mem, bit pcs, bit cond, bit br);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mem; PCSrcD = pcs; CondExE = cond; BranchTakenE = br;
  endtask

  vecT vecs[$];

  initial begin
    // ADD R1 ; SUB R2,R1,R3 -> forward from M
    vecs.push_back(mk(1, 2, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // ADD R1 ; NOP ; ORR R4,R5,R1 -> SrcB from W for one cycle
    vecs.push_back(mk(1, 2, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // LDR R1 ; ADD R2,R1,R1 -> one stall, then both operands from W
    vecs.push_back(mk(1, 2, 2, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1));
    // MOV PC,R0 with condition passing: 3 stalled fetches, 4 flushed decodes
    vecs.push_back(mk(1, 0, 0, 15, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    // MOV PC,R0 with condition failing in Execute
    vecs.push_back(mk(1, 0, 0, 15, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    // LDR R1 in E, dependent in D, branch taken -> branch wins
    vecs.push_back(mk(1, 2, 2, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // reset discards a load that would otherwise forward from W
    vecs.push_back(mk(1, 2, 2, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // R15 sources never stall or forward, even against a write to R15
    vecs.push_back(mk(0, 2, 2, 15, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 15, 15, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    compare("reset_state", 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rst) reset = 1'b1;
      drive(vecs[i].ra1, vecs[i].ra2, vecs[i].wa3, vecs[i].rw, vecs[i].mem,
            vecs[i].pcs, vecs[i].cond, vecs[i].br);
      #1;
      compare($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].sf, vecs[i].sd,
              vecs[i].fd, vecs[i].fe, vecs[i].cnt);
      reset = 1'b0;
    end

    // stall counter saturates at its maximum
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 15, 1, 0, 1, 1, 0);
    #1 reset = 1'b0;
    repeat (CNT_MAX + 5) @(posedge clk);
    @(negedge clk); #1;
    compare("saturate", 0, 0, 1, 0, 1, 0, CNT_MAX);

    // randomized run against the reference model
    @(negedge clk);
    reset = 1'b1;
    modelClear();
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] r1, r2, w;
      bit pcs;
      if (n > 0) @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        modelClear();
      end
      r1  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      r2  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      pcs = ($urandom_range(0, 9) == 0);
      w   = pcs ? 4'hF : (($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 3)));
      drive(r1, r2, w, pcs | ($urandom_range(0, 3) != 0), !pcs && ($urandom_range(0, 2) == 0),
            pcs, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      #1;
      modelEval();
      compare($sformatf("rand%0d", n), eFa, eFb, eSf, eSd, eFd, eFe, mCount);
      reset = 1'b0;
      modelStep();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
